// File: rtl/pcs10g_pkg.sv
// Shared 10GBASE-R PCS definitions: sync-header codes, block-sync FSM states
// and the header validity check.
package pcs10g_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        SLIPWAIT = 2'd1,
        LOCKED   = 2'd2
    } bsync_state_t;

    function automatic logic sh_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/block_sync_rx_32b.sv
// 66b block synchronizer on the 32-bit RX path: hunts for sync-header lock by
// slipping the gearbox, monitors lock per window, and gates data to the descrambler.
module block_sync_rx_32b
    import pcs10g_pkg::*;
#(
    parameter int LOCK_CNT  = 64,
    parameter int INVLD_MAX = 16,
    parameter int SLIP_WAIT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] din,
    input  logic [1:0]  ctrlin,
    input  logic        din_en,
    input  logic        evenin,
    output logic [31:0] dout,
    output logic [1:0]  ctrlout,
    output logic        dout_en,
    output logic        evenout,
    output logic        slip,
    output logic        block_lock
);

    localparam int SHW = $clog2(LOCK_CNT + 1);
    localparam int IVW = $clog2(INVLD_MAX + 1);
    localparam int WTW = $clog2(SLIP_WAIT + 1);

    bsync_state_t   state_q, state_d;
    logic [SHW-1:0] sh_cnt_q, sh_cnt_d;
    logic [IVW-1:0] invld_q, invld_d;
    logic [WTW-1:0] wait_q, wait_d;
    logic           lock_q, lock_d;
    logic           slip_q, slip_d;
    logic           gate_q, gate_d;
    logic [31:0]    dout_q;
    logic [1:0]     ctrl_q;
    logic           en_q, even_q;

    logic hdr_ev, hdr_ok, gate_now;

    assign hdr_ev = din_en & evenin;
    assign hdr_ok = sh_valid(ctrlin);
    // Even word uses lock as it stood before this header; odd word reuses it.
    assign gate_now = hdr_ev ? lock_q : gate_q;

    always_comb begin
        state_d  = state_q;
        sh_cnt_d = sh_cnt_q;
        invld_d  = invld_q;
        wait_d   = wait_q;
        lock_d   = lock_q;
        slip_d   = 1'b0;
        gate_d   = gate_now;

        case (state_q)
            HUNT: begin
                if (hdr_ev) begin
                    if (hdr_ok) begin
                        if (sh_cnt_q == SHW'(LOCK_CNT - 1)) begin
                            lock_d   = 1'b1;
                            sh_cnt_d = '0;
                            invld_d  = '0;
                            state_d  = LOCKED;
                        end else begin
                            sh_cnt_d = sh_cnt_q + SHW'(1);
                        end
                    end else begin
                        slip_d   = 1'b1;
                        sh_cnt_d = '0;
                        wait_d   = WTW'(SLIP_WAIT);
                        state_d  = SLIPWAIT;
                    end
                end
            end
            SLIPWAIT: begin
                if (wait_q == '0) state_d = HUNT;
                else              wait_d  = wait_q - WTW'(1);
            end
            LOCKED: begin
                if (hdr_ev) begin
                    // Loss of lock wins over a window end on the same header.
                    if (!hdr_ok && invld_q == IVW'(INVLD_MAX - 1)) begin
                        lock_d   = 1'b0;
                        slip_d   = 1'b1;
                        sh_cnt_d = '0;
                        invld_d  = '0;
                        wait_d   = WTW'(SLIP_WAIT);
                        state_d  = SLIPWAIT;
                    end else if (sh_cnt_q == SHW'(LOCK_CNT - 1)) begin
                        sh_cnt_d = '0;
                        invld_d  = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_q + SHW'(1);
                        if (!hdr_ok) invld_d = invld_q + IVW'(1);
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            sh_cnt_q <= '0;
            invld_q  <= '0;
            wait_q   <= '0;
            lock_q   <= 1'b0;
            slip_q   <= 1'b0;
            gate_q   <= 1'b0;
            dout_q   <= '0;
            ctrl_q   <= '0;
            en_q     <= 1'b0;
            even_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_cnt_q <= sh_cnt_d;
            invld_q  <= invld_d;
            wait_q   <= wait_d;
            lock_q   <= lock_d;
            slip_q   <= slip_d;
            gate_q   <= gate_d;
            if (din_en) begin
                dout_q <= din;
                ctrl_q <= ctrlin;
            end
            en_q     <= din_en & gate_now;
            even_q   <= evenin;
        end
    end

    assign dout       = dout_q;
    assign ctrlout    = ctrl_q;
    assign dout_en    = en_q;
    assign evenout    = even_q;
    assign slip       = slip_q;
    assign block_lock = lock_q;

endmodule

// File: tb/tb_block_sync_rx_32b.sv
// Randomized and directed bench for block_sync_rx_32b against a behavioural
// lock/slip model counting headers and blind cycles.
module tb_block_sync_rx_32b;

    localparam int LOCK_CNT  = 64;
    localparam int INVLD_MAX = 16;
    localparam int SLIP_WAIT = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din = '0;
    logic [1:0]  ctrlin = '0;
    logic        din_en = 1'b0;
    logic        evenin = 1'b0;
    logic [31:0] dout;
    logic [1:0]  ctrlout;
    logic        dout_en, evenout, slip, block_lock;

    block_sync_rx_32b #(.LOCK_CNT(LOCK_CNT), .INVLD_MAX(INVLD_MAX), .SLIP_WAIT(SLIP_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .ctrlin(ctrlin), .din_en(din_en), .evenin(evenin),
        .dout(dout), .ctrlout(ctrlout), .dout_en(dout_en), .evenout(evenout),
        .slip(slip), .block_lock(block_lock)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // model state: consecutive good headers, window headers/bad, blind edges left
    int m_good, m_hdr, m_bad, m_blind;
    bit m_lock, m_gate;
    logic [31:0] nx_dout, ex_dout;
    logic [1:0]  nx_ctrl, ex_ctrl;
    logic        nx_en, ex_en, nx_even, ex_even, nx_slip, ex_slip, nx_lock, ex_lock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("dout", dout, ex_dout);
            chk("ctrlout", ctrlout, ex_ctrl);
            chk("dout_en", dout_en, ex_en);
            chk("evenout", evenout, ex_even);
            chk("slip", slip, ex_slip);
            chk("block_lock", block_lock, ex_lock);
        end
    end

    task automatic model_reset();
        m_good = 0; m_hdr = 0; m_bad = 0; m_blind = 0; m_lock = 0; m_gate = 0;
        {nx_dout, nx_ctrl, nx_en, nx_even, nx_slip, nx_lock} = '0;
        {ex_dout, ex_ctrl, ex_en, ex_even, ex_slip, ex_lock} = '0;
    endtask

    task automatic model_step();
        bit hev, ok, g;
        hev = din_en && evenin;
        ok  = (ctrlin == 2'b01) || (ctrlin == 2'b10);
        g   = hev ? m_lock : m_gate;
        nx_en   = din_en && g;
        nx_dout = din_en ? din : ex_dout;
        nx_ctrl = din_en ? ctrlin : ex_ctrl;
        nx_even = evenin;
        nx_slip = 1'b0;
        if (hev) m_gate = m_lock;
        if (m_blind > 0) m_blind--;
        else if (hev) begin
            if (!m_lock) begin
                if (ok) begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin m_lock = 1; m_good = 0; m_hdr = 0; m_bad = 0; end
                end else begin
                    m_good = 0; nx_slip = 1; m_blind = SLIP_WAIT + 1;
                end
            end else begin
                m_hdr++;
                if (!ok) m_bad++;
                if (m_bad == INVLD_MAX) begin
                    m_lock = 0; m_hdr = 0; m_bad = 0; nx_slip = 1; m_blind = SLIP_WAIT + 1;
                end else if (m_hdr == LOCK_CNT) begin
                    m_hdr = 0; m_bad = 0;
                end
            end
        end
        nx_lock = m_lock;
    endtask

    task automatic tick(input logic [31:0] d, input logic [1:0] c, input bit en, input bit ev);
        din = d; ctrlin = c; din_en = en; evenin = ev;
        model_step();
        @(posedge clk); #1;
        {ex_dout, ex_ctrl, ex_en, ex_even, ex_slip, ex_lock} =
            {nx_dout, nx_ctrl, nx_en, nx_even, nx_slip, nx_lock};
    endtask

    function automatic logic [1:0] good_sh(input int i);
        return (i % 2 == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic odd_word();
        tick($urandom(), 2'($urandom_range(0, 3)), 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int slips;
        logic [31:0] held;
        bit ev;
        logic [1:0] c;
        int pbad;

        chk_on = 1'b1;
        do_reset();
        chk("reset_outs", {dout, ctrlout, dout_en, evenout, slip, block_lock}, '0);

        // Lock acquisition with 64 alternating valid headers
        for (int b = 0; b <= 64; b++) begin
            tick($urandom(), good_sh(b), 1'b1, 1'b1);
            if (b == 62) chk("lock_before_64", block_lock, 0);
            if (b == 63) chk("lock_at_64", block_lock, 1);
            if (b == 64) chk("dout_en_next_even", dout_en, 1);
            odd_word();
            if (b == 63) chk("dout_en_odd_of_64th", dout_en, 0);
        end

        // Invalid header on the 10th header while hunting
        do_reset();
        slips = 0;
        for (int w = 0; w < 2 * 107; w++) begin
            int b;
            b = w / 2;
            if (w % 2 == 1) odd_word();
            else if (b < 9 || b > 26) tick($urandom(), good_sh(b), 1'b1, 1'b1);
            else tick($urandom(), 2'b11, 1'b1, 1'b1);
            if (w == 18) chk("slip_first", slip, 1);
            if (w == 19) chk("slip_one_cycle", slip, 0);
            if (w > 19 && w < 52 && slip) slips++;
            if (w == 52) chk("slip_second", slip, 1);
            if (w == 2 * 105) chk("relock_needs_64_a", block_lock, 0);
            if (w == 2 * 106) chk("relock_needs_64_b", block_lock, 1);
        end
        chk("slip_quiet_wait", slips, 0);

        // Two windows with 15 invalid headers each keep lock
        for (int win = 0; win < 2; win++) begin
            for (int i = 0; i < 64; i++) begin
                c = (i % 4 == 1 && i < 60) ? 2'b00 : good_sh(i);
                tick($urandom(), c, 1'b1, 1'b1);
                odd_word();
            end
            chk("lock_holds_15", block_lock, 1);
        end
        // 16 invalid headers in the next window lose lock
        for (int i = 0; i < 17; i++) begin
            tick($urandom(), (i < 16) ? 2'b11 : 2'b01, 1'b1, 1'b1);
            if (i == 15) begin
                chk("lock_lost_16", block_lock, 0);
                chk("slip_on_16", slip, 1);
                chk("dout_en_failing_even", dout_en, 1);
            end
            if (i == 16) chk("dout_en_after_loss", dout_en, 0);
            odd_word();
            if (i == 15) chk("dout_en_failing_odd", dout_en, 1);
        end

        // din_en toggling: lock counts header events, not cycles
        do_reset();
        for (int b = 0; b < 64; b++) begin
            held = $urandom();
            tick(held, good_sh(b), 1'b1, 1'b1);
            if (b == 62) chk("gap_lock_before", block_lock, 0);
            if (b == 63) chk("gap_lock_at_64", block_lock, 1);
            tick($urandom(), 2'b11, 1'b0, 1'b1);
            if (b == 5) chk("gap_dout_hold", dout, held);
            odd_word();
            tick($urandom(), 2'b00, 1'b0, 1'b0);
        end

        // Reset pulse mid-window while locked
        for (int b = 0; b < 20; b++) begin
            tick($urandom(), good_sh(b), 1'b1, 1'b1);
            odd_word();
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk("async_reset_outs", {dout, ctrlout, dout_en, evenout, slip, block_lock}, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int b = 0; b < 64; b++) begin
            tick($urandom(), good_sh(b), 1'b1, 1'b1);
            if (b == 62) chk("post_reset_lock_before", block_lock, 0);
            if (b == 63) chk("post_reset_lock_at_64", block_lock, 1);
            odd_word();
        end

        // Randomized stream with varying header error rate
        do_reset();
        ev = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            bit en;
            pbad = (i >= 1500 && i < 2500) ? 22 : 1;
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < pbad) c = $urandom_range(0, 1) ? 2'b00 : 2'b11;
            else c = $urandom_range(0, 1) ? 2'b01 : 2'b10;
            tick($urandom(), c, en, ev);
            if (en) ev = ($urandom_range(0, 199) == 0) ? ev : ~ev;
        end

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
